bitstream_frame_loader: RTL and testbench
=========================================

Name: bitstream_frame_loader

Overview:
- Upstream stage of every tile ConfigMem in one fabric column.
- Consumes a 32-bit bitstream word stream over a valid/ready handshake and decodes sync, desync and frame-header words.
- Assembles one frame's data across all rows of the column into the FrameData bus, then fires a one-cycle one-hot FrameStrobe so the tile frame latches capture it.
- One instance per column. Frames addressed to other columns are consumed and discarded.

Parameters:
- FrameBitsPerRow, 32: width of each row's FrameData slice and of one stream word. Only 32 is supported.
- MaxFramesPerCol, 20: width of FrameStrobe and number of addressable frames.
- NumberOfRows, 4: data words per frame, one per tile row.
- ColumnId, 0: 8-bit column index this instance responds to.

Ports:
- CLK  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- in_data  in  FrameBitsPerRow  bitstream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  word accepted when in_valid and in_ready are both high at a rising edge.
- FrameData  out  NumberOfRows*FrameBitsPerRow  row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  out  MaxFramesPerCol  one-hot, one-cycle write pulse.
- synced  out  1  high while between a sync word and a desync word.
- error  out  1  sticky protocol-error flag.
- frames_written  out  16  count of strobes issued, wraps at 0xFFFF->0.

Behaviour:
- Reset: one clock, synchronous active-low. While resetn==0 at a rising edge:
  - state IDLE; FrameData=0; FrameStrobe=0; synced=0; error=0; frames_written=0; row counter=0.
  - in_ready=0 during reset.
- Reset mid-frame aborts the frame without any strobe.
- Accepted word = in_valid && in_ready at the edge. No word is consumed otherwise.

State machine:
- IDLE:
  - in_ready=1.
  - Word 0xFAB0_FAB1 -> SYNCED, synced=1.
  - All other words are dropped silently, with no error.
- SYNCED:
  - in_ready=1.
  - 0xFAB0_FAB0 -> IDLE, synced=0.
  - 0xFAB0_FAB1 -> no effect.
  - Header word: in_data[31:28]==4'h1. Fields are col=[27:20] and frame=[15:8]; all other bits are ignored.
    - col==ColumnId and frame<MaxFramesPerCol -> LOAD; latch frame; row counter=0.
    - col==ColumnId and frame>=MaxFramesPerCol -> set error; go to SKIP.
    - col!=ColumnId -> SKIP, with no error.
  - Any other word -> set error; stay in SYNCED.
- LOAD:
  - in_ready=1.
  - Each accepted word is raw data, including words equal to the sync/desync patterns.
  - The word is written into FrameData row[row counter]; the counter increments.
  - On acceptance of row NumberOfRows-1 -> STROBE.
  - Rows not yet written keep their previous values.
- SKIP:
  - in_ready=1.
  - Consumes exactly NumberOfRows words; FrameData is unchanged.
  - Then -> SYNCED. No strobe is issued.
- STROBE:
  - in_ready=0.
  - FrameStrobe has exactly the latched frame bit set, for one cycle.
  - frames_written increments.
  - -> HOLD.
- HOLD:
  - in_ready=0; FrameStrobe=0.
  - FrameData is held so it stays stable across the strobe falling edge.
  - -> SYNCED.

Latency and timing:
- The first FrameStrobe cycle is the cycle after the last data word is accepted.
- Minimum spacing between consecutive strobes is NumberOfRows+3 cycles: header, N data, STROBE, HOLD.
- FrameData changes only on LOAD word acceptance. It persists after a frame for debug.
- All outputs are registered. in_ready is decoded from the state register only, never from in_valid.
- in_valid deasserting mid-frame stalls the FSM indefinitely with no timeout.
- error clears only on reset.

Test Plan:
- Sync then frame: ColumnId=0, NumberOfRows=4. Send 0xFAB0_FAB1, header 0x1000_0500, then data 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required: FrameData=0x44444444_33333333_22222222_11111111.
  - FrameStrobe=0x00020 for exactly one cycle, the cycle after the 4th word.
  - in_ready=0 for 2 cycles; frames_written=1; error=0.
- Foreign column: header 0x1030_0200 plus 4 data words.
  - Required: no strobe; FrameData unchanged; error=0; next header is accepted.
- Bad frame index: header 0x1000_1400 (frame=20).
  - Required: error=1; the 4 following words are skipped; no strobe.
- Unsynced and desync handling:
  - Header or data before the sync word -> no strobe, error=0, synced=0.
  - 0xFAB0_FAB0 inside LOAD is stored as data.
  - 0xFAB0_FAB0 in SYNCED -> synced=0.
- Backpressure and stall: toggle in_valid randomly during the LOAD of header 0x1000_1300.
  - Required: FrameStrobe=0x80000 once, with correct row ordering.
  - No words are accepted during STROBE/HOLD even with in_valid=1.
- Reset mid-LOAD after 2 data words: assert resetn=0 for 1 cycle.
  - Required: all outputs return to their reset values (FrameData=0, error=0, frames_written=0); no strobe is ever emitted for the aborted frame.

Source files
------------

// File: rtl/bitstream_frame_loader.sv
// Column configuration frame loader: decodes a 32-bit bitstream word stream, assembles one
// frame across all rows of the column and issues a one-hot write strobe to the tile latches.
module bitstream_frame_loader #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumberOfRows    = 4,
  parameter int unsigned ColumnId        = 0
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              in_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    synced,
  output logic                                    error,
  output logic [15:0]                             frames_written
);

  localparam int unsigned RowW   = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int unsigned FrameW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);
  localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
  localparam logic [31:0] DesyncWord = 32'hFAB0_FAB0;

  typedef enum logic [2:0] {
    StIdle,
    StSynced,
    StLoad,
    StSkip,
    StStrobe,
    StHold
  } state_e;

  state_e                                  state_q, state_d;
  logic [RowW-1:0]                         row_q, row_d;
  logic [FrameW-1:0]                       frame_q, frame_d;
  logic [NumberOfRows*FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0]              strobe_q, strobe_d;
  logic                                    synced_q, synced_d;
  logic                                    error_q, error_d;
  logic [15:0]                             count_q, count_d;
  logic                                    ready_q, ready_d;

  logic accept;
  logic is_sync, is_desync, is_header, hdr_ours, hdr_frame_ok;

  assign accept       = in_valid && ready_q;
  assign is_sync      = (in_data == SyncWord);
  assign is_desync    = (in_data == DesyncWord);
  assign is_header    = (in_data[31:28] == 4'h1);
  assign hdr_ours     = (in_data[27:20] == 8'(ColumnId));
  assign hdr_frame_ok = (32'(in_data[15:8]) < MaxFramesPerCol);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    frame_d  = frame_q;
    data_d   = data_q;
    strobe_d = '0;
    synced_d = synced_q;
    error_d  = error_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        // Anything before the sync word is dropped without flagging an error.
        if (accept && is_sync) begin
          state_d  = StSynced;
          synced_d = 1'b1;
        end
      end
      StSynced: begin
        if (accept) begin
          if (is_desync) begin
            state_d  = StIdle;
            synced_d = 1'b0;
          end else if (is_sync) begin
            state_d = StSynced;
          end else if (is_header) begin
            row_d = '0;
            if (hdr_ours && hdr_frame_ok) begin
              state_d = StLoad;
              frame_d = FrameW'(in_data[15:8]);
            end else begin
              state_d = StSkip;
              if (hdr_ours) begin
                error_d = 1'b1;
              end
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // Every word here is payload, even if it matches the sync/desync patterns.
        if (accept) begin
          data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
          row_d = row_q + 1'b1;
          if (row_q == LastRow) begin
            state_d  = StStrobe;
            row_d    = '0;
            strobe_d = MaxFramesPerCol'(1) << frame_q;
            count_d  = count_q + 16'd1;
          end
        end
      end
      StSkip: begin
        if (accept) begin
          row_d = row_q + 1'b1;
          if (row_q == LastRow) begin
            state_d = StSynced;
            row_d   = '0;
          end
        end
      end
      StStrobe: begin
        state_d = StHold;
      end
      StHold: begin
        state_d = StSynced;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered ready: low for the strobe and hold cycles so FrameData stays put.
    ready_d = (state_d == StIdle) || (state_d == StSynced) ||
              (state_d == StLoad) || (state_d == StSkip);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= StIdle;
      row_q    <= '0;
      frame_q  <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      synced_q <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= 16'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      synced_q <= synced_d;
      error_q  <= error_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready       = ready_q;
  assign FrameData      = data_q;
  assign FrameStrobe    = strobe_q;
  assign synced         = synced_q;
  assign error          = error_q;
  assign frames_written = count_q;

endmodule

// File: tb/tb_bitstream_frame_loader.sv
// Self-checking bench for bitstream_frame_loader: directed scenarios plus a randomized word
// stream, all checked each cycle against a word-level behavioural model.
module tb_bitstream_frame_loader;

  localparam int unsigned W   = 32;
  localparam int unsigned MF  = 20;
  localparam int unsigned N   = 4;
  localparam int unsigned COL = 0;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic           CLK = 1'b0;
  logic           resetn = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] FrameData;
  logic [MF-1:0]  FrameStrobe;
  logic           synced;
  logic           error;
  logic [15:0]    frames_written;

  bitstream_frame_loader #(
    .FrameBitsPerRow(W),
    .MaxFramesPerCol(MF),
    .NumberOfRows   (N),
    .ColumnId       (COL)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .synced        (synced),
    .error         (error),
    .frames_written(frames_written)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word-level reference model: what a stream of accepted words must produce.
  bit             m_ready = 0;
  int             m_block = 0;   // cycles still closed after a completed frame
  bit             m_sync = 0;
  int             m_mode = 0;    // 0 decode, 1 collecting payload, 2 discarding payload
  int             m_idx = 0;
  int             m_frame = 0;
  logic [N*W-1:0] m_fd = '0;
  logic [MF-1:0]  m_strobe = '0;
  bit             m_err = 0;
  logic [15:0]    m_cnt = '0;

  logic [31:0] wq[$];
  int p_valid = 100;
  int strobes_seen = 0;
  logic [MF-1:0] last_strobe = '0;

  task automatic model_edge();
    bit acc;
    logic [31:0] d;
    if (!resetn) begin
      m_ready = 0; m_block = 0; m_sync = 0; m_mode = 0; m_idx = 0; m_frame = 0;
      m_fd = '0; m_strobe = '0; m_err = 0; m_cnt = '0;
      return;
    end
    acc = in_valid && m_ready;
    d = in_data;
    m_strobe = '0;
    if (m_block > 0) m_block--;
    if (acc) begin
      if (wq.size() > 0) void'(wq.pop_front());
      if (m_mode == 1) begin
        m_fd[m_idx*W +: W] = d;
        m_idx++;
        if (m_idx == N) begin
          m_mode = 0;
          m_strobe = MF'(1) << m_frame;
          m_cnt++;
          m_block = 2;
        end
      end else if (m_mode == 2) begin
        m_idx--;
        if (m_idx == 0) m_mode = 0;
      end else if (!m_sync) begin
        if (d == SYNC) m_sync = 1;
      end else if (d == DESYNC) begin
        m_sync = 0;
      end else if (d == SYNC) begin
        m_sync = 1;
      end else if (d[31:28] == 4'h1) begin
        if (d[27:20] == 8'(COL) && int'(d[15:8]) < int'(MF)) begin
          m_mode = 1; m_idx = 0; m_frame = int'(d[15:8]);
        end else begin
          if (d[27:20] == 8'(COL)) m_err = 1;
          m_mode = 2; m_idx = N;
        end
      end else begin
        m_err = 1;
      end
    end
    m_ready = (m_block == 0);
  endtask

  task automatic compare_all();
    check_eq("in_ready", in_ready, m_ready);
    check_eq("strobe", FrameStrobe, m_strobe);
    check_eq("frame_data", FrameData, m_fd);
    check_eq("synced", synced, m_sync);
    check_eq("error", error, m_err);
    check_eq("frames_written", frames_written, m_cnt);
    if (FrameStrobe !== '0) begin
      strobes_seen++;
      last_strobe = FrameStrobe;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  task automatic run_queue(input int budget);
    int n = 0;
    while (wq.size() > 0 && n < budget) begin
      in_valid = ($urandom_range(99) < p_valid);
      in_data  = in_valid ? wq[0] : $urandom;
      cycle();
      n++;
    end
    in_valid = 1'b0;
    check_eq("queue_drained", wq.size(), 0);
  endtask

  function automatic logic [31:0] header(input logic [7:0] col, input logic [7:0] fr);
    logic [3:0] mid = 4'($urandom);
    logic [7:0] lo  = 8'($urandom);
    return {4'h1, col, mid, fr, lo};
  endfunction

  initial begin
    int s0;
    logic [31:0] w;
    int k;

    // Reset
    @(negedge CLK);
    do_reset();
    check_eq("rst_fd", FrameData, '0);
    check_eq("rst_cnt", frames_written, 16'd0);
    check_eq("rst_ready", in_ready, 1'b0);
    idle(1);
    check_eq("post_rst_ready", in_ready, 1'b1);

    // Sync then frame 5, followed back-to-back by a foreign-column frame
    p_valid = 100;
    wq = '{SYNC, 32'h1000_0500, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
           32'h1030_0200, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
    run_queue(100);
    idle(3);
    check_eq("t1_fd", FrameData, 128'h44444444_33333333_22222222_11111111);
    check_eq("t1_strobe_val", last_strobe, 20'h00020);
    check_eq("t1_strobes", strobes_seen, 1);
    check_eq("t1_cnt", frames_written, 16'd1);
    check_eq("t2_err", error, 1'b0);

    // Next header for this column still accepted after the foreign frame
    wq = '{32'h1000_0100, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
    run_queue(100);
    idle(3);
    check_eq("t2_next_strobe", last_strobe, 20'h00002);
    check_eq("t2_strobes", strobes_seen, 2);

    // Out-of-range frame index
    s0 = strobes_seen;
    wq = '{32'h1000_1400, 32'h9999_0001, 32'h9999_0002, 32'h9999_0003, 32'h9999_0004};
    run_queue(100);
    idle(3);
    check_eq("t3_err", error, 1'b1);
    check_eq("t3_nostrobe", strobes_seen, s0);
    check_eq("t3_fd", FrameData, 128'h88888888_77777777_66666666_55555555);

    // Unsynced words, desync pattern as payload, desync in SYNCED
    do_reset();
    s0 = strobes_seen;
    wq = '{32'h1000_0500, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
    run_queue(100);
    idle(2);
    check_eq("t4_nostrobe", strobes_seen, s0);
    check_eq("t4_err", error, 1'b0);
    check_eq("t4_synced", synced, 1'b0);
    wq = '{SYNC, 32'h1000_0300, 32'hC0DE_0000, DESYNC, SYNC, 32'hC0DE_0003};
    run_queue(100);
    idle(3);
    check_eq("t4_payload", FrameData, {32'hC0DE_0003, SYNC, DESYNC, 32'hC0DE_0000});
    check_eq("t4_synced_after", synced, 1'b1);
    wq = '{DESYNC};
    run_queue(20);
    idle(1);
    check_eq("t4_desync", synced, 1'b0);

    // Backpressure during the load of frame 19
    p_valid = 50;
    wq = '{SYNC, 32'h1000_1300, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    run_queue(400);
    idle(3);
    check_eq("t5_strobe", last_strobe, 20'h80000);
    check_eq("t5_fd", FrameData, 128'hD0000003_D0000002_D0000001_D0000000);

    // Reset mid-load after two payload words, with error already set
    p_valid = 100;
    wq = '{32'h0000_0007, 32'h1000_0400, 32'hE000_0000, 32'hE000_0001};
    run_queue(100);
    check_eq("t6_err_before", error, 1'b1);
    s0 = strobes_seen;
    do_reset();
    check_eq("t6_fd", FrameData, '0);
    check_eq("t6_err", error, 1'b0);
    check_eq("t6_cnt", frames_written, 16'd0);
    idle(8);
    check_eq("t6_nostrobe", strobes_seen, s0);

    // Randomized mixed stream
    p_valid = 70;
    k = 0;
    while (k < 300) begin
      case ($urandom_range(9))
        0: wq.push_back(SYNC);
        1: wq.push_back(DESYNC);
        2, 3, 4, 5: begin
          w = header(($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'(COL),
                     8'($urandom_range(0, 25)));
          wq.push_back(w);
          for (int r = 0; r < int'(N); r++) begin
            case ($urandom_range(7))
              0: wq.push_back(SYNC);
              1: wq.push_back(DESYNC);
              default: wq.push_back($urandom);
            endcase
          end
          k += N;
        end
        default: wq.push_back($urandom);
      endcase
      k++;
    end
    run_queue(5000);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
